// File: rtl/uart_pkg.sv
// Shared types and constants for the UART loopback block.
package uart_pkg;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam logic        LINE_IDLE       = 1'b1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clock_freq,
                                                    input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer, start-bit glitch reject, centre sampling, framing check.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic                       sync1_q, sync2_q, prev_q;
  rx_state_e                  state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [2:0]                 bit_q;
  logic [FRAME_DATA_BITS-1:0] shift_q;
  logic [7:0]                 data_q;
  logic                       valid_q;
  logic                       err_q;

  logic half_end_c, bit_end_c;
  assign half_end_c = (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign bit_end_c  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= LINE_IDLE;
      sync2_q <= LINE_IDLE;
      prev_q  <= LINE_IDLE;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= serial_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      unique case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          err_q <= 1'b0;
          if (prev_q && !sync2_q) state_q <= RX_START;
        end
        RX_START: begin
          if (half_end_c) begin
            cnt_q <= '0;
            bit_q <= '0;
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (bit_end_c) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[FRAME_DATA_BITS-1:1]};
            if (bit_q == 3'(FRAME_DATA_BITS - 1)) state_q <= RX_STOP;
            else bit_q <= bit_q + 3'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          // After a framing error, hold here until the line idles high again.
          if (err_q) begin
            if (sync2_q) state_q <= RX_IDLE;
          end else if (bit_end_c) begin
            cnt_q <= '0;
            if (sync2_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= RX_IDLE;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/top_level_uart.sv
// UART loopback shell: TX holding register and 8N1 serializer feeding an on-chip receiver.
module top_level_uart
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLOCK_FREQ = 38400000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] uart_tx,
  input  logic       start_transmit,
  input  logic       load_data,
  output logic [7:0] uart_rx,
  output logic       valid,
  output logic       tx_done
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 8) begin : g_bad_rate
    $error("top_level_uart: CLKS_PER_BIT must be >= 8");
  end

  tx_state_e                  tx_state_q;
  logic [CNT_W-1:0]           tx_cnt_q;
  logic [2:0]                 tx_bit_q;
  logic [FRAME_DATA_BITS-1:0] tx_shift_q;
  logic [7:0]                 hold_q;
  logic                       pending_q;
  logic                       tx_line_q;
  logic                       stop_done_q;
  logic                       tx_done_q;

  logic tx_bit_end_c;
  assign tx_bit_end_c = (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Line is driven one cycle after the state, so stop_done_q delays tx_done to match the line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      pending_q   <= 1'b0;
      tx_line_q   <= LINE_IDLE;
      stop_done_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      stop_done_q <= 1'b0;
      if (stop_done_q) tx_done_q <= 1'b1;
      unique case (tx_state_q)
        TX_IDLE: begin
          tx_line_q <= LINE_IDLE;
          tx_cnt_q  <= '0;
          if (load_data) begin
            hold_q    <= uart_tx;
            pending_q <= 1'b1;
          end else if (pending_q && start_transmit) begin
            tx_state_q <= TX_START;
            tx_shift_q <= hold_q;
            pending_q  <= 1'b0;
            tx_done_q  <= 1'b0;
          end
        end
        TX_START: begin
          tx_line_q <= 1'b0;
          if (tx_bit_end_c) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_DATA: begin
          tx_line_q <= tx_shift_q[0];
          if (tx_bit_end_c) begin
            tx_cnt_q   <= '0;
            tx_shift_q <= tx_shift_q >> 1;
            if (tx_bit_q == 3'(FRAME_DATA_BITS - 1)) tx_state_q <= TX_STOP;
            else tx_bit_q <= tx_bit_q + 3'(1);
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_STOP: begin
          tx_line_q <= LINE_IDLE;
          if (tx_bit_end_c) begin
            tx_cnt_q    <= '0;
            tx_state_q  <= TX_IDLE;
            stop_done_q <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .serial_i(tx_line_q),
    .data_o  (uart_rx),
    .valid_o (valid)
  );

  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_top_level_uart.sv
// Self-checking bench for top_level_uart at CLKS_PER_BIT=16 with a receive scoreboard.
module tb_top_level_uart;

  localparam int CPB   = 16;
  localparam int BOUND = 1 + (19 * CPB) / 2 + 4;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line bits in time order, [0] = start bit
    int         hold;
    bit         midload;
    bit         both;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] uart_tx = 8'h00;
  logic       start_transmit = 1'b0;
  logic       load_data = 1'b0;
  logic [7:0] uart_rx;
  logic       valid;
  logic       tx_done;
  logic       line;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_idx  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] seen_data[$];
  int         seen_cyc[$];
  frame_t     tbl[6];

  top_level_uart #(
    .BAUD_RATE (2400000),
    .CLOCK_FREQ(38400000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_tx       (uart_tx),
    .start_transmit(start_transmit),
    .load_data     (load_data),
    .uart_rx       (uart_rx),
    .valid         (valid),
    .tx_done       (tx_done)
  );

  assign line = dut.tx_line_q;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      seen_data.push_back(uart_rx);
      seen_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rx();
    logic [7:0] e;
    chk("rx_count", 32'(seen_data.size()), 32'(rd_idx + 1));
    if (seen_data.size() > rd_idx && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rx_data", 32'(seen_data[rd_idx]), 32'(e));
      rd_idx = seen_data.size();
    end else begin
      exp_q.delete();
      rd_idx = seen_data.size();
    end
  endtask

  task automatic run_frame(input frame_t f);
    int t0;
    int lat;
    load_data = 1'b1;
    uart_tx   = f.data;
    if (f.both) begin
      start_transmit = 1'b1;
      tick();
      chk("load_wins_txdone", 32'(tx_done), 32'd1);
      load_data = 1'b0;
      tick();
      chk("load_wins_late_start", 32'(tx_done), 32'd0);
    end else begin
      tick();
      load_data      = 1'b0;
      start_transmit = 1'b1;
      tick();
      chk("tx_done_drop", 32'(tx_done), 32'd0);
    end
    t0 = cyc;
    exp_q.push_back(f.data);
    chk("line_at_T", 32'(line), 32'd1);
    for (int k = 1; k <= 10 * CPB + 1; k++) begin
      if (k >= f.hold) start_transmit = 1'b0;
      if (f.midload && k == 3 * CPB) begin
        load_data = 1'b1;
        uart_tx   = 8'hFF;
      end
      if (f.midload && k == 3 * CPB + 2) load_data = 1'b0;
      tick();
      if ((k - 1) % CPB == CPB / 2)
        chk($sformatf("line_bit%0d", (k - 1) / CPB), 32'(line), 32'(f.frame[(k-1)/CPB]));
      if (k == 10 * CPB) chk("tx_done_before_end", 32'(tx_done), 32'd0);
    end
    chk("tx_done_set", 32'(tx_done), 32'd1);
    if (seen_cyc.size() > rd_idx) begin
      lat = seen_cyc[rd_idx] - t0;
      chk("rx_latency", 32'(lat > 0 && lat <= BOUND), 32'd1);
    end
    check_rx();
    chk("uart_rx_hold", 32'(uart_rx), 32'(f.data));
  endtask

  initial begin
    bit ok;
    tbl[0] = '{8'h27, 10'b1001001110, 1, 1'b0, 1'b0};
    tbl[1] = '{8'h33, 10'b1001100110, 4, 1'b0, 1'b0};
    tbl[2] = '{8'hA5, 10'b1101001010, 1, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 10'b1000000000, 1, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 10'b1111111110, 2, 1'b0, 1'b0};
    tbl[5] = '{8'h3C, 10'b1001111000, 1, 1'b0, 1'b1};

    reset = 1'b0;
    repeat (4) tick();
    chk("rst_uart_rx", 32'(uart_rx), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    chk("rst_line", 32'(line), 32'd1);
    reset = 1'b1;
    tick();

    foreach (tbl[i]) run_frame(tbl[i]);

    // Start with nothing pending: no frame, tx_done untouched.
    ok = 1'b1;
    start_transmit = 1'b1;
    repeat (2 * CPB) begin
      tick();
      if (line !== 1'b1) ok = 1'b0;
    end
    start_transmit = 1'b0;
    chk("no_pending_line_idle", 32'(ok), 32'd1);
    repeat (12 * CPB) tick();
    chk("no_pending_no_valid", 32'(seen_data.size()), 32'(rd_idx));
    chk("no_pending_tx_done", 32'(tx_done), 32'd1);

    // Reset in the middle of the data bits.
    load_data = 1'b1;
    uart_tx   = 8'h5A;
    tick();
    load_data      = 1'b0;
    start_transmit = 1'b1;
    tick();
    start_transmit = 1'b0;
    repeat (3 * CPB) tick();
    reset = 1'b0;
    tick();
    chk("midrst_line", 32'(line), 32'd1);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_tx_done", 32'(tx_done), 32'd0);
    chk("midrst_uart_rx", 32'(uart_rx), 32'd0);
    reset = 1'b1;
    ok = 1'b1;
    start_transmit = 1'b1;
    repeat (2 * CPB) begin
      tick();
      if (line !== 1'b1) ok = 1'b0;
    end
    start_transmit = 1'b0;
    chk("postrst_no_pending", 32'(ok), 32'd1);
    repeat (12 * CPB) tick();
    chk("postrst_no_valid", 32'(seen_data.size()), 32'(rd_idx));
    run_frame('{8'h5A, 10'b1010110100, 1, 1'b0, 1'b0});

    repeat (4 * CPB) tick();
    chk("no_extra_valid", 32'(seen_data.size()), 32'(rd_idx));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
